// File: rtl/resource_arbiter_if.sv
// resource_arbiter_if: bundles the requester-side and resource-side signals of
// resource_arbiter.
//   req, req_valid, req_data : per-pipeline request, valid data strobe, packed data
//   grant                    : one-hot grant back to the pipelines
//   res_in_valid/res_in_data : transfer into the shared resource
//   res_out_valid/res_out_data : resource response
//   rsp_valid/rsp_data       : one-hot response strobe, broadcast response data
//   busy, timeout_err, stray_rsp : status
// master = pipelines + resource (environment), slave = the arbiter.
interface resource_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        grant;
   logic                      res_in_valid;
   logic [DATA_W-1:0]         res_in_data;
   logic                      res_out_valid;
   logic [DATA_W-1:0]         res_out_data;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      busy;
   logic                      timeout_err;
   logic                      stray_rsp;

   modport master (
      output req, req_valid, req_data, res_out_valid, res_out_data,
      input  grant, res_in_valid, res_in_data, rsp_valid, rsp_data,
      input  busy, timeout_err, stray_rsp
   );

   modport slave (
      input  req, req_valid, req_data, res_out_valid, res_out_data,
      output grant, res_in_valid, res_in_data, rsp_valid, rsp_data,
      output busy, timeout_err, stray_rsp
   );
endinterface

// File: rtl/resource_arbiter.sv
// resource_arbiter: round-robin owner of one shared resource among NUM_REQ stall
// pipelines. IDLE picks a requester, GRANT waits for its valid data and forwards it,
// WAIT holds ownership until the resource answers (or times out) and routes the
// response to the owner only.
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : resource_arbiter_if slave modport (requests, grant, resource in/out,
//           responses, status)
// NUM_REQ and DATA_W must match the parameters of the connected interface.
module resource_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic               clk,
   input logic               reset,
   resource_arbiter_if.slave bus
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);
   localparam logic [IdxW-1:0] PtrInit = IdxW'(NUM_REQ - 1);

   typedef enum logic [1:0] {StIdle, StGrant, StWait} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] owner_q, owner_d;
   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic [TmrW-1:0] timer_q, timer_d;
   logic            timeout_q, timeout_d;
   logic            stray_q, stray_d;
   logic [IdxW-1:0] pick_idx;

   // Search offsets 1..NUM_REQ from rr_ptr; walking from far to near lets the nearest
   // set request overwrite, so the first hit after rr_ptr wins.
   always_comb begin
      int unsigned     cand;
      logic [IdxW-1:0] cand_idx;
      pick_idx = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = 32'(rr_ptr_q) + 32'(k);
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = cand[IdxW-1:0];
         if (bus.req[cand_idx]) pick_idx = cand_idx;
      end
   end

   always_comb begin
      state_d          = state_q;
      owner_d          = owner_q;
      rr_ptr_d         = rr_ptr_q;
      timer_d          = timer_q;
      timeout_d        = 1'b0;
      stray_d          = 1'b0;
      bus.grant        = '0;
      bus.res_in_valid = 1'b0;
      bus.rsp_valid    = '0;
      case (state_q)
         StIdle: begin
            if (|bus.req) begin
               owner_d  = pick_idx;
               rr_ptr_d = pick_idx;
               state_d  = StGrant;
            end
         end
         StGrant: begin
            bus.grant[owner_q] = 1'b1;
            // A transfer wins even if req drops in the same cycle.
            if (bus.req_valid[owner_q]) begin
               bus.res_in_valid = 1'b1;
               timer_d          = '0;
               state_d          = StWait;
            end else if (!bus.req[owner_q]) begin
               state_d = StIdle;
            end
         end
         StWait: begin
            // A response on the last timer cycle beats the timeout.
            if (bus.res_out_valid) begin
               bus.rsp_valid[owner_q] = 1'b1;
               state_d                = StIdle;
            end else if (timer_q == TmrLast) begin
               timeout_d = 1'b1;
               state_d   = StIdle;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (bus.res_out_valid && (state_q != StWait)) stray_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         owner_q   <= '0;
         rr_ptr_q  <= PtrInit;
         timer_q   <= '0;
         timeout_q <= 1'b0;
         stray_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
         stray_q   <= stray_d;
      end
   end

   assign bus.res_in_data = bus.req_data[32'(owner_q) * DATA_W +: DATA_W];
   assign bus.rsp_data    = bus.res_out_data;
   assign bus.busy        = (state_q != StIdle);
   assign bus.timeout_err = timeout_q;
   assign bus.stray_rsp   = stray_q;

endmodule

// File: doc/resource_arbiter.md
# resource_arbiter

Round-robin arbiter that shares one downstream resource among `NUM_REQ` three-stage stall pipelines. Each pipeline's final stage raises its request and holds its valid data while stalled on `~grant[i]`. The arbiter grants one requester per transaction and steers that requester's data into the resource. It then holds ownership until the resource answers and routes the response back to the owner only, with a timeout guard against a hung resource.

## Interface
- `NUM_REQ`, 4: number of requesting pipelines (2..8).
- `DATA_W`, 32: datapath width.
- `TIMEOUT_CYCLES`, 255: max WAIT cycles before forced release (≥1).

- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `req` in NUM_REQ: `arbiter_req` from each pipeline.
- `req_valid` in NUM_REQ: `out_valid_to_resource` from each pipeline's final stage.
- `req_data` in NUM_REQ*DATA_W: `resource_input` per pipeline; slice i = bits [i*DATA_W +: DATA_W].
- `grant` out NUM_REQ: one-hot grant; pipeline i stalls on `~grant[i]`.
- `res_in_valid` out 1: data strobe to resource.
- `res_in_data` out DATA_W: data to resource.
- `res_out_valid` in 1: resource response strobe.
- `res_out_data` in DATA_W: resource response data.
- `rsp_valid` out NUM_REQ: one-hot response strobe to the owner.
- `rsp_data` out DATA_W: response data, broadcast to all pipelines.
- `busy` out 1: high in GRANT or WAIT.
- `timeout_err` out 1: one-cycle pulse on forced release.
- `stray_rsp` out 1: one-cycle pulse when `res_out_valid` arrives outside WAIT.

## Operation
- **FSM states:** IDLE, GRANT, WAIT.
- **Registers:**
  - `state`
  - `owner` (clog2 NUM_REQ bits)
  - `rr_ptr` (last granted index)
  - `timer` (clog2(TIMEOUT_CYCLES+1) bits)
  - registered `timeout_err` and `stray_rsp`
- **IDLE:**
  - `grant` = 0.
  - If `req` is nonzero, pick the first set bit searching from `rr_ptr+1` upward with wrap to 0.
  - Load `owner` and `rr_ptr` with that index; next state is GRANT.
- **GRANT:**
  - `grant` = one-hot(`owner`), decoded from registered state.
  - Transfer condition: `req_valid[owner]` high.
  - Transfer cycle: `res_in_valid` = 1 and `res_in_data` = `req_data[owner]`, both combinational. Clear `timer`; next state is WAIT.
  - Else if `req[owner]` is low: abandon, next state is IDLE.
  - Else stay in GRANT.
- **WAIT:**
  - `grant` = 0.
  - On `res_out_valid`: `rsp_valid[owner]` = 1 and `rsp_data` = `res_out_data`, combinational pass-through. Next state is IDLE.
  - Else if `timer` == TIMEOUT_CYCLES-1: pulse `timeout_err` next cycle; next state is IDLE.
  - Else `timer` increments.
- **Outside WAIT:**
  - `rsp_valid` = 0 and `rsp_data` = `res_out_data`.
  - A `res_out_valid` in IDLE or GRANT is dropped and pulses `stray_rsp` next cycle.
- **Invariants:**
  - `res_in_valid` is only ever high in GRANT.
  - `grant` and `rsp_valid` are never high at the same time.
  - At most one `grant` bit is set.

## Timing
- **Reset values:**
  - `state` = IDLE, `owner` = 0, `rr_ptr` = NUM_REQ-1 (requester 0 wins first), `timer` = 0.
  - All outputs 0; `res_in_data` and `rsp_data` follow their combinational sources.
- **Latency:**
  - `req` sampled in cycle t (IDLE) → `grant` high in cycle t+1.
  - Earliest resource transfer is t+1; WAIT begins at t+2.
  - Response in cycle r → `rsp_valid` in cycle r; IDLE at r+1; next grant at r+2 at the earliest.
- **Simultaneous events:**
  - Response and timeout in the same cycle: the response wins and there is no `timeout_err`.
  - `req[owner]` dropping in the same cycle that `req_valid[owner]` is high: the transfer still occurs.
- **Wrap-around:** with `rr_ptr` = NUM_REQ-1, the search starts at index 0.
- **Reset mid-transaction:** asynchronously returns to IDLE and drops `grant` immediately. An in-flight response after reset is a stray response.

## Test plan
- **Single requester:** reset, then `req`=0001 with `req_valid[0]`=1 and data 0xDEADBEEF at t0.
  - `grant`=0001 at t1, with `res_in_valid`=1 and `res_in_data`=0xDEADBEEF at t1.
  - `res_out_valid` with 0x12345678 at t4 → `rsp_valid`=0001 and `rsp_data`=0x12345678 at t4; `busy`=0 at t5.
- **Round-robin fairness:** `req`=1111 held, resource answering 2 cycles after each transfer.
  - Grant order must be 0,1,2,3,0.
  - A requester must never receive two grants in a row while others wait.
- **Timeout:** TIMEOUT_CYCLES=4 with no response.
  - `timeout_err` pulses exactly once, 5 cycles after the transfer cycle (4 WAIT cycles plus the registered pulse).
  - The next grant goes to the next requester.
- **Stall hold and abandon:**
  - Owner 2 with `req_valid[2]`=0 for 3 cycles → `grant`=0100 held; `res_in_valid`=0 throughout.
  - Then `req[2]` drops → IDLE with no transfer.
- **Stray response and collision:**
  - `res_out_valid` in IDLE → `stray_rsp` pulse and `rsp_valid`=0.
  - Response arriving on the timeout cycle → `rsp_valid` asserted and `timeout_err`=0.
- **Async reset mid-WAIT:** assert `reset` between clock edges.
  - `busy` and `grant` go to 0 immediately.
  - After release, `req`=1000 is granted at index 3.
